// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing the 8-digit display between requesters.
// Source 0 may preempt a running hold; grants latch data onto output_data.
module seg_display_scheduler #(
   parameter int unsigned N_SRC       = 4,
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   parameter logic [31:0] IDLE_VALUE  = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_SRC-1:0]       req,
   input  logic [32*N_SRC-1:0]    data,
   output logic [N_SRC-1:0]       ack,
   output logic [31:0]            output_data,
   output logic [2:0]             cur_src,
   output logic                   busy
);

   localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned LW = $clog2(N_SRC);
   localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [LW-1:0] LAST_RST = LW'(N_SRC - 1);
   localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

   typedef enum logic {
      IDLE,
      SHOW
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        out_q, out_d;
   logic [2:0]         cur_q, cur_d;
   logic [LW-1:0]      last_q, last_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_SRC-1:0]   ack_q, ack_d;
   logic               busy_q, busy_d;

   logic [N_SRC-1:0]   elig;
   logic [LW-1:0]      pick_idx;
   logic               pick_ok;
   logic [LW-1:0]      gidx;
   logic               gnt;

   assign elig = req & ~ack_q;

   // Round-robin search: nearest eligible index after last; later
   // iterations have smaller offsets and so win.
   always_comb begin
      pick_idx = '0;
      pick_ok  = 1'b0;
      for (int unsigned k = N_SRC; k >= 1; k--) begin
         if (elig[(32'(last_q) + k) % N_SRC]) begin
            pick_idx = LW'((32'(last_q) + k) % N_SRC);
            pick_ok  = 1'b1;
         end
      end
   end

   // Next-state: grant, preempt, count down the hold or fall back to IDLE.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cur_d   = cur_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      ack_d   = '0;
      gnt     = 1'b0;
      gidx    = pick_idx;
      unique case (state_q)
         IDLE: gnt = pick_ok;
         SHOW: begin
            if (cnt_q != '0) begin
               if (elig[0] && cur_q != 3'd0) begin
                  gnt  = 1'b1;
                  gidx = '0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end else if (pick_ok) begin
               gnt = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: ;
      endcase
      if (gnt) begin
         ack_d   = ONE_HOT0 << gidx;
         out_d   = data[32*gidx +: 32];
         cur_d   = 3'(gidx);
         last_d  = gidx;
         cnt_d   = CNT_LOAD;
         state_d = SHOW;
         busy_d  = 1'b1;
      end
   end

   // State and output registers; reset drops any pending grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         out_q   <= IDLE_VALUE;
         cur_q   <= 3'd0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   assign ack         = ack_q;
   assign output_data = out_q;
   assign cur_src     = cur_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed scenarios plus random
// requesters, all checked against a timestamp-based grant model.
module tb_seg_display_scheduler;

   localparam int N = 4;
   localparam int H = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    req = '0;
   logic [127:0]  data = '0;
   logic [3:0]    ack;
   logic [31:0]   output_data;
   logic [2:0]    cur_src;
   logic          busy;

   int compared = 0;
   int mismatched = 0;

   // reference model state
   logic [3:0]  m_ack;
   logic [31:0] m_out;
   int          m_cur;
   int          m_last;
   int          m_gedge;
   bit          m_busy;
   int          n = 0;

   int g_src[$];
   int g_edge[$];

   seg_display_scheduler #(
      .N_SRC(N),
      .HOLD_CYCLES(H),
      .IDLE_VALUE(32'h0000_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .data(data),
      .ack(ack),
      .output_data(output_data),
      .cur_src(cur_src),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      m_ack  = '0;
      m_out  = 32'h0;
      m_cur  = 0;
      m_last = N - 1;
      m_busy = 1'b0;
   endtask

   function automatic int rr(input logic [3:0] e);
      for (int k = 1; k <= N; k++)
         if (e[(m_last + k) % N]) return (m_last + k) % N;
      return -1;
   endfunction

   task automatic mgrant(input int i);
      m_ack   = 4'b0001 << i;
      m_out   = data[32*i +: 32];
      m_cur   = i;
      m_last  = i;
      m_gedge = n;
      m_busy  = 1'b1;
   endtask

   // one clock edge of the model, using the inputs present at the edge
   task automatic model_edge();
      logic [3:0] e;
      e = req & ~m_ack;
      m_ack = '0;
      n++;
      if (!m_busy) begin
         if (e != 0) mgrant(rr(e));
      end else if (n - m_gedge < H) begin
         if (e[0] && m_cur != 0) mgrant(0);
      end else begin
         if (e != 0) mgrant(rr(e));
         else m_busy = 1'b0;
      end
   endtask

   task automatic check_all();
      check("ack", 32'(ack), 32'(m_ack));
      check("output_data", output_data, m_out);
      check("cur_src", 32'(cur_src), 32'(m_cur));
      check("busy", 32'(busy), 32'(m_busy));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (ack != 0) begin
         g_src.push_back(m_cur);
         g_edge.push_back(n);
      end
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      mreset();
      check_all();
      #1;
      rst = 1'b1;
   endtask

   task automatic set_src(input int i);
      data[32*i +: 32] = $urandom;
      req[i] = 1'b1;
   endtask

   // requesters: drop after ack, else maybe raise or withdraw
   task automatic req_update(input logic [3:0] mask, input int up_pct,
                             input int wd_pct);
      for (int i = 0; i < N; i++) begin
         if (!mask[i]) continue;
         if (ack[i]) req[i] = 1'b0;
         else if (!req[i] && $urandom_range(99) < up_pct) set_src(i);
         else if (req[i] && $urandom_range(99) < wd_pct) req[i] = 1'b0;
      end
   endtask

   initial begin
      mreset();
      #1;
      check_all();
      #1;
      rst = 1'b1;

      // single grant then expiry to IDLE
      data[95:64] = 32'hCAFE_0002;
      req = 4'b0100;
      step();
      check("t1_ack", 32'(ack), 32'h4);
      check("t1_data", output_data, 32'hCAFE_0002);
      check("t1_cur", 32'(cur_src), 32'd2);
      req = '0;
      for (int i = 0; i < 3; i++) step();
      check("t1_busy_hold", 32'(busy), 32'd1);
      step();
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_keep", output_data, 32'hCAFE_0002);

      // withdrawn request in IDLE
      req[3] = 1'b1;
      #2;
      req[3] = 1'b0;
      step();
      check("t5_noack", 32'(ack), 32'd0);
      check("t5_keep", output_data, 32'hCAFE_0002);

      // continuous requests on 1..3: round robin, H apart
      do_reset();
      for (int i = 1; i < N; i++) set_src(i);
      g_src.delete();
      g_edge.delete();
      for (int i = 0; i < 13; i++) begin
         step();
         req_update(4'b1110, 100, 0);
      end
      check("t2_count", 32'(g_src.size()), 32'd4);
      for (int i = 0; i < g_src.size() && i < 4; i++) begin
         check("t2_src", 32'(g_src[i]), 32'(1 + (i % 3)));
         if (i > 0)
            check("t2_gap", 32'(g_edge[i] - g_edge[i-1]), 32'(H));
      end

      // source 0 preempts a running hold of source 1
      do_reset();
      req = '0;
      set_src(1);
      step();
      check("t3_cur1", 32'(cur_src), 32'd1);
      req = '0;
      step();
      set_src(0);
      step();
      check("t3_ack0", 32'(ack), 32'h1);
      check("t3_cur0", 32'(cur_src), 32'd0);
      req = '0;
      set_src(2);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_wait", 32'(ack), 32'd0);
      end
      step();
      check("t3_next", 32'(ack), 32'h4);

      // source 0 re-requesting while shown does not preempt
      req = '0;
      for (int i = 0; i < 4; i++) step();
      set_src(0);
      step();
      check("t4_g0", 32'(ack), 32'h1);
      req = '0;
      step();
      set_src(0);
      set_src(3);
      for (int i = 0; i < 2; i++) begin
         step();
         check("t4_nopre", 32'(ack), 32'd0);
      end
      step();
      check("t4_rr3", 32'(ack), 32'h8);
      req[3] = 1'b0;
      step();
      check("t4_pre0", 32'(ack), 32'h1);

      // asynchronous reset with ack pending
      #2;
      rst = 1'b0;
      #1;
      mreset();
      check("t6_ack", 32'(ack), 32'd0);
      check("t6_data", output_data, 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      req = '0;
      set_src(1);
      set_src(3);
      #1;
      rst = 1'b1;
      step();
      check("t6_first", 32'(ack), 32'h2);

      // random requesters
      req = '0;
      for (int i = 0; i < 400; i++) begin
         step();
         req_update(4'b1111, 30, 5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
